// File: rtl/ex_stage.sv
// ex_stage: execute stage. A combinational ALU feeds the EX/MEM output register.
// Define MUL_EN to add the iterative shift-add multiplier, which stalls upstream while busy.
module ex_stage #(
  parameter int DW      = 64,
  parameter int MUL_CYC = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] alu_op_num1_i,
  input  logic [DW-1:0] alu_op_num2_i,
  input  logic [2:0]    alu_operation_i,
  input  logic          alu_add_sub_i,
  input  logic          alu_shift_i,
  input  logic          word_intercept_i,
  input  logic [DW-1:0] data_rs2_i,
  input  logic [4:0]    addr_rd_i,
  input  logic          reg_wr_en_i,
  input  logic [2:0]    load_code_i,
  input  logic [2:0]    store_code_i,
`ifdef MUL_EN
  input  logic          mul_req_i,
  input  logic [1:0]    mul_op_i,
`endif
  input  logic          hold_n,
  input  logic          flush_i,
  output logic [DW-1:0] alu_result_o,
  output logic [DW-1:0] data_rs2_o,
  output logic [4:0]    addr_rd_o,
  output logic          reg_wr_en_o,
  output logic [2:0]    load_code_o,
  output logic [2:0]    store_code_o,
  output logic          stall_o
);

  localparam int SW = $clog2(DW);

  localparam logic       REG_WR_DIS = 1'b0;
  localparam logic [2:0] LOAD_NOPE  = 3'b000;
  localparam logic [2:0] STORE_NOPE = 3'b000;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SR   = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [DW-1:0] result;
    logic [DW-1:0] rs2;
    logic [4:0]    rd;
    logic          wr_en;
    logic [2:0]    load_code;
    logic [2:0]    store_code;
  } ex_mem_t;

  localparam ex_mem_t BUBBLE = '{
    result:     '0,
    rs2:        '0,
    rd:         '0,
    wr_en:      REG_WR_DIS,
    load_code:  LOAD_NOPE,
    store_code: STORE_NOPE
  };

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  alu_op_e       alu_op;
  logic [SW-1:0] shamt;
  logic [4:0]    shamt_w;
  logic [DW-1:0] add_res;
  logic [DW-1:0] alu_res;
  logic [31:0]   word_res;
  logic          word_op;

  assign alu_op  = alu_op_e'(alu_operation_i);
  assign shamt   = alu_op_num2_i[SW-1:0];
  assign shamt_w = alu_op_num2_i[4:0];
  assign add_res = alu_add_sub_i ? alu_op_num1_i - alu_op_num2_i
                                 : alu_op_num1_i + alu_op_num2_i;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    alu_res  = '0;
    word_res = '0;
    word_op  = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        alu_res  = add_res;
        word_res = add_res[31:0];
        word_op  = 1'b1;
      end
      ALU_SLL: begin
        alu_res  = alu_op_num1_i << shamt;
        word_res = alu_op_num1_i[31:0] << shamt_w;
        word_op  = 1'b1;
      end
      ALU_SLT:  alu_res = {{(DW-1){1'b0}}, $signed(alu_op_num1_i) < $signed(alu_op_num2_i)};
      ALU_SLTU: alu_res = {{(DW-1){1'b0}}, alu_op_num1_i < alu_op_num2_i};
      ALU_XOR:  alu_res = alu_op_num1_i ^ alu_op_num2_i;
      ALU_SR: begin
        word_op = 1'b1;
        // Kept as if/else: a ?: mixing signed and unsigned arms would turn >>> logical.
        if (alu_shift_i) begin
          alu_res  = $signed(alu_op_num1_i) >>> shamt;
          word_res = $signed(alu_op_num1_i[31:0]) >>> shamt_w;
        end else begin
          alu_res  = alu_op_num1_i >> shamt;
          word_res = alu_op_num1_i[31:0] >> shamt_w;
        end
      end
      ALU_OR:   alu_res = alu_op_num1_i | alu_op_num2_i;
      ALU_AND:  alu_res = alu_op_num1_i & alu_op_num2_i;
      default:  alu_res = '0;
    endcase
    if (word_intercept_i && word_op)
      alu_res = {{(DW-32){word_res[31]}}, word_res};
  end

  logic [DW-1:0] ex_result;

`ifdef MUL_EN
  // ---------------------------------------------------------------------------
  // Iterative multiplier: magnitudes are multiplied, sign is fixed up in DONE.
  // ---------------------------------------------------------------------------
  localparam int CW = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_BUSY,
    MUL_DONE
  } mul_state_e;

  mul_state_e      mul_state;
  logic [CW-1:0]   mul_cnt;
  logic [2*DW-1:0] mcand;
  logic [2*DW-1:0] acc;
  logic [2*DW-1:0] product;
  logic [DW-1:0]   mplier;
  logic [DW-1:0]   abs_a;
  logic [DW-1:0]   abs_b;
  logic [DW-1:0]   mul_res;
  logic            a_neg;
  logic            b_neg;
  logic            neg_q;
  logic            low_q;
  logic            word_q;

  // rs1 is signed for MUL/MULH/MULHSU, rs2 only for MUL/MULH.
  assign a_neg = (mul_op_i != 2'b11) & alu_op_num1_i[DW-1];
  assign b_neg = ~mul_op_i[1] & alu_op_num2_i[DW-1];
  assign abs_a = a_neg ? -alu_op_num1_i : alu_op_num1_i;
  assign abs_b = b_neg ? -alu_op_num2_i : alu_op_num2_i;

  assign product = neg_q ? -acc : acc;

  always_comb begin
    mul_res = product[2*DW-1:DW];
    if (low_q)
      mul_res = word_q ? {{(DW-32){product[31]}}, product[31:0]} : product[DW-1:0];
  end

  // Gated by flush so upstream is released in the same cycle the multiply is killed.
  assign stall_o = ~flush_i & (((mul_state == MUL_IDLE) & mul_req_i) | (mul_state == MUL_BUSY));

  // NOTE: only control state is reset; the datapath registers are always loaded on acceptance before use.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      mul_state <= MUL_IDLE;
      mul_cnt   <= '0;
    end else if (flush_i) begin
      mul_state <= MUL_IDLE;
    end else if (hold_n) begin
      case (mul_state)
        MUL_IDLE: begin
          if (mul_req_i) begin
            mcand     <= {{DW{1'b0}}, abs_a};
            mplier    <= abs_b;
            acc       <= '0;
            mul_cnt   <= '0;
            neg_q     <= a_neg ^ b_neg;
            low_q     <= (mul_op_i == 2'b00);
            word_q    <= word_intercept_i;
            mul_state <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          if (mplier[0])
            acc <= acc + mcand;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          mul_cnt <= mul_cnt + 1'b1;
          if (mul_cnt == CW'(MUL_CYC - 1))
            mul_state <= MUL_DONE;
        end
        MUL_DONE: mul_state <= MUL_IDLE;
        default:  mul_state <= MUL_IDLE;
      endcase
    end
  end

  assign ex_result = (mul_state == MUL_DONE) ? mul_res : alu_res;
`else
  assign stall_o   = 1'b0;
  assign ex_result = alu_res;
`endif

  // ---------------------------------------------------------------------------
  // EX/MEM output register
  // ---------------------------------------------------------------------------
  ex_mem_t ex_next;
  ex_mem_t ex_q;

  assign ex_next = '{
    result:     ex_result,
    rs2:        data_rs2_i,
    rd:         addr_rd_i,
    wr_en:      reg_wr_en_i,
    load_code:  load_code_i,
    store_code: store_code_i
  };

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_n || flush_i)
      ex_q <= BUBBLE;
    else if (hold_n)
      ex_q <= stall_o ? BUBBLE : ex_next;
  end

  assign alu_result_o = ex_q.result;
  assign data_rs2_o   = ex_q.rs2;
  assign addr_rd_o    = ex_q.rd;
  assign reg_wr_en_o  = ex_q.wr_en;
  assign load_code_o  = ex_q.load_code;
  assign store_code_o = ex_q.store_code;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; multiplier steps are built only when MUL_EN is defined.
module tb_ex_stage;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] num1, num2, rs2;
  logic [2:0]    op;
  logic          add_sub, shift_ar, word;
  logic [4:0]    rd;
  logic          wr_en;
  logic [2:0]    load_code, store_code;
  logic          hold_n, flush;
  logic [DW-1:0] alu_result_o, data_rs2_o;
  logic [4:0]    addr_rd_o;
  logic          reg_wr_en_o;
  logic [2:0]    load_code_o, store_code_o;
  logic          stall_o;
`ifdef MUL_EN
  logic          mul_req;
  logic [1:0]    mul_op;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_stage #(.DW(DW), .MUL_CYC(64)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .alu_op_num1_i    (num1),
    .alu_op_num2_i    (num2),
    .alu_operation_i  (op),
    .alu_add_sub_i    (add_sub),
    .alu_shift_i      (shift_ar),
    .word_intercept_i (word),
    .data_rs2_i       (rs2),
    .addr_rd_i        (rd),
    .reg_wr_en_i      (wr_en),
    .load_code_i      (load_code),
    .store_code_i     (store_code),
`ifdef MUL_EN
    .mul_req_i        (mul_req),
    .mul_op_i         (mul_op),
`endif
    .hold_n           (hold_n),
    .flush_i          (flush),
    .alu_result_o     (alu_result_o),
    .data_rs2_o       (data_rs2_o),
    .addr_rd_o        (addr_rd_o),
    .reg_wr_en_o      (reg_wr_en_o),
    .load_code_o      (load_code_o),
    .store_code_o     (store_code_o),
    .stall_o          (stall_o)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [2:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                     input logic sub, input logic sh, input logic w);
    op = o; num1 = a; num2 = b; add_sub = sub; shift_ar = sh; word = w;
  endtask

`ifdef MUL_EN
  // Issues a multiply, counts stall cycles, optionally holds 3 cycles, then checks the result.
  task automatic run_mul(input string tag, input logic [1:0] mop, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic w, input logic [DW-1:0] exp,
                         input int hold_at, input int exp_cycles);
    int   cyc = 0;
    logic bubble_ok = 1'b1;
    logic [DW-1:0] held;
    alu(3'b000, a, b, 1'b0, 1'b0, w);
    mul_op = mop; mul_req = 1'b1; wr_en = 1'b1; rd = 5'd9;
    held = '0;
    while (stall_o && cyc < 200) begin
      if (cyc == hold_at) begin hold_n = 1'b0; held = alu_result_o; end
      if (cyc == hold_at + 3) hold_n = 1'b1;
      step();
      cyc++;
      if (reg_wr_en_o !== 1'b0 || alu_result_o !== '0) bubble_ok = 1'b0;
      if (hold_n == 1'b0 && alu_result_o !== held) bubble_ok = 1'b0;
    end
    check({tag, "_stall_cycles"}, DW'(cyc), DW'(exp_cycles));
    check({tag, "_bubbles"}, DW'(bubble_ok), 64'd1);
    step();                       // DONE edge with mul_req still high
    mul_req = 1'b0;
    check({tag, "_result"}, alu_result_o, exp);
    check({tag, "_wr_en"}, DW'(reg_wr_en_o), 64'd1);
    check({tag, "_no_restart"}, DW'(stall_o), 64'd0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1; hold_n = 1'b1; flush = 1'b0;
    alu(3'b000, 64'd3, 64'd4, 1'b0, 1'b0, 1'b0);
    rs2 = 64'hDEAD; rd = 5'd7; wr_en = 1'b1; load_code = 3'b010; store_code = 3'b001;
`ifdef MUL_EN
    mul_req = 1'b0; mul_op = 2'b00;
`endif
    step();
    step();
    check("rst_result", alu_result_o, 64'd0);
    check("rst_wr_en", DW'(reg_wr_en_o), 64'd0);
    check("rst_load", DW'(load_code_o), 64'd0);
    check("rst_store", DW'(store_code_o), 64'd0);
    check("rst_rd", DW'(addr_rd_o), 64'd0);
    check("rst_rs2", data_rs2_o, 64'd0);
    check("rst_stall", DW'(stall_o), 64'd0);
    rst_n = 1'b0;

    alu(3'b000, 64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1);
    rs2 = 64'h1234; rd = 5'd5; load_code = 3'b011; store_code = 3'b010;
    step();
    check("addw_overflow", alu_result_o, 64'hFFFF_FFFF_8000_0000);
    check("pass_rs2", data_rs2_o, 64'h1234);
    check("pass_rd", DW'(addr_rd_o), 64'd5);
    check("pass_wr_en", DW'(reg_wr_en_o), 64'd1);
    check("pass_load", DW'(load_code_o), 64'd3);
    check("pass_store", DW'(store_code_o), 64'd2);
    load_code = 3'b000; store_code = 3'b000;

    alu(3'b101, 64'h8000_0000_0000_0000, 64'd63, 1'b0, 1'b1, 1'b0); step();
    check("sra_63", alu_result_o, 64'hFFFF_FFFF_FFFF_FFFF);
    alu(3'b101, 64'h8000_0000_0000_0000, 64'd63, 1'b0, 1'b0, 1'b0); step();
    check("srl_63", alu_result_o, 64'd1);
    alu(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0); step();
    check("slt_neg", alu_result_o, 64'd1);
    alu(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0); step();
    check("sltu_big", alu_result_o, 64'd0);
    alu(3'b000, 64'd5, 64'd7, 1'b1, 1'b0, 1'b0); step();
    check("sub_wrap", alu_result_o, 64'hFFFF_FFFF_FFFF_FFFE);
    alu(3'b001, 64'd1, 64'd64, 1'b0, 1'b0, 1'b0); step();
    check("sll_amt_mod64", alu_result_o, 64'd1);
    alu(3'b001, 64'd1, 64'd31, 1'b0, 1'b0, 1'b1); step();
    check("sllw_31", alu_result_o, 64'hFFFF_FFFF_8000_0000);
    alu(3'b101, 64'h0000_0000_8000_0000, 64'd4, 1'b0, 1'b1, 1'b1); step();
    check("sraw_4", alu_result_o, 64'hFFFF_FFFF_F800_0000);
    alu(3'b101, 64'h0000_0000_8000_0000, 64'd4, 1'b0, 1'b0, 1'b1); step();
    check("srlw_4", alu_result_o, 64'h0000_0000_0800_0000);
    alu(3'b100, 64'hF0F0, 64'hFF00, 1'b0, 1'b0, 1'b0); step();
    check("xor", alu_result_o, 64'h0FF0);

    alu(3'b110, 64'hF0F0, 64'hFF00, 1'b0, 1'b0, 1'b0);
    hold_n = 1'b0; step();
    check("hold_1", alu_result_o, 64'h0FF0);
    step();
    check("hold_2", alu_result_o, 64'h0FF0);
    hold_n = 1'b1; step();
    check("or_after_hold", alu_result_o, 64'hFFF0);
    alu(3'b111, 64'hF0F0, 64'hFF00, 1'b0, 1'b0, 1'b0); step();
    check("and", alu_result_o, 64'hF000);

    flush = 1'b1; step();
    check("flush_result", alu_result_o, 64'd0);
    check("flush_wr_en", DW'(reg_wr_en_o), 64'd0);
    flush = 1'b0;

`ifdef MUL_EN
    run_mul("mulh", 2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, -1, 65);
    run_mul("mul", 2'b00, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA, -1, 65);
    run_mul("mulhu", 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFE, -1, 65);
    run_mul("mul_hold", 2'b00, 64'd7, 64'd6, 1'b0, 64'd42, 20, 68);

    // flush in the 10th BUSY cycle
    alu(3'b000, 64'd9, 64'd9, 1'b0, 1'b0, 1'b0);
    mul_op = 2'b00; mul_req = 1'b1;
    step();
    repeat (9) step();
    check("flush_busy_stall_before", DW'(stall_o), 64'd1);
    flush = 1'b1; mul_req = 1'b0;
    check("flush_stall_same_cycle", DW'(stall_o), 64'd0);
    step();
    flush = 1'b0;
    check("flush_stall_next", DW'(stall_o), 64'd0);
    check("flush_mul_result", alu_result_o, 64'd0);
    check("flush_mul_wr_en", DW'(reg_wr_en_o), 64'd0);
    alu(3'b000, 64'd1, 64'd1, 1'b0, 1'b0, 1'b0); step();
    check("after_flush_add", alu_result_o, 64'd2);

    // reset mid-multiply
    mul_req = 1'b1;
    repeat (6) step();
    rst_n = 1'b1; mul_req = 1'b0;
    step();
    rst_n = 1'b0;
    check("rst_mid_stall", DW'(stall_o), 64'd0);
    check("rst_mid_wr_en", DW'(reg_wr_en_o), 64'd0);
    alu(3'b000, 64'd2, 64'd3, 1'b0, 1'b0, 1'b0); step();
    check("after_rst_add", alu_result_o, 64'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
